// File: rtl/schwap_spill_fill.sv
// Spill/fill engine moving the schwappable registers between the register file and data memory.
// Optional SCHWAP_AUTOSWAP_EN adds a bank-swap strobe at the end of every spill.
module schwap_spill_fill #(
  parameter int DATA_W   = 16,
  parameter int MADDR_W  = 16,
  parameter int REG_BASE = 12,
  parameter int NUM_REGS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [MADDR_W-1:0] cmd_base,
`ifdef SCHWAP_AUTOSWAP_EN
  input  logic [3:0]         cmd_bank,
  output logic [3:0]         schwap_reg,
  output logic               schwap_clk,
`endif
  output logic               busy,
  output logic               done,
  output logic [3:0]         rf_read_addr,
  input  logic [DATA_W-1:0]  rf_read_data,
  output logic               rf_write,
  output logic [3:0]         rf_write_addr,
  output logic [DATA_W-1:0]  rf_write_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SPILL   = 3'd1;
  localparam logic [2:0] FILL_RD = 3'd2;
  localparam logic [2:0] FILL_WR = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
`ifdef SCHWAP_AUTOSWAP_EN
  localparam logic [2:0] SWAP    = 3'd5;
`endif

  localparam logic [3:0] RegBase = 4'(REG_BASE);
  localparam logic [1:0] IdxLast = 2'(NUM_REGS - 1);

  logic [2:0]         state;
  logic [1:0]         idx;
  logic [MADDR_W-1:0] baseLatched;
  logic [DATA_W-1:0]  holdReg;
  logic [3:0]         regIdx;
  logic [MADDR_W-1:0] memIdxAddr;
  logic               lastIdx;
`ifdef SCHWAP_AUTOSWAP_EN
  logic [3:0]         bankLatched;
`endif

  assign regIdx     = RegBase + {2'b00, idx};
  assign memIdxAddr = baseLatched + MADDR_W'(idx);
  assign lastIdx    = (idx == IdxLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            idx   <= 2'd0;
            state <= cmd_op ? FILL_RD : SPILL;
          end
        end
        // Back-to-back spill: mem_req stays high while idx advances.
        SPILL: begin
          if (mem_ack) begin
            if (lastIdx) begin
`ifdef SCHWAP_AUTOSWAP_EN
              state <= SWAP;
`else
              state <= DONE;
`endif
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        FILL_RD: begin
          if (mem_ack) state <= FILL_WR;
        end
        FILL_WR: begin
          if (lastIdx) begin
            state <= DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= FILL_RD;
          end
        end
`ifdef SCHWAP_AUTOSWAP_EN
        SWAP:    state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data holding registers need no reset: every output using them is gated by state.
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      baseLatched <= cmd_base;
`ifdef SCHWAP_AUTOSWAP_EN
      bankLatched <= cmd_bank;
`endif
    end
    if (state == FILL_RD && mem_ack) holdReg <= mem_rdata;
  end

  always_comb begin
    cmd_ready     = (state == IDLE);
    busy          = (state != IDLE);
    done          = (state == DONE);
    rf_read_addr  = 4'd0;
    rf_write      = 1'b0;
    rf_write_addr = 4'd0;
    rf_write_data = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
`ifdef SCHWAP_AUTOSWAP_EN
    schwap_clk    = 1'b0;
    schwap_reg    = 4'd0;
`endif
    case (state)
      SPILL: begin
        rf_read_addr = regIdx;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = memIdxAddr;
        mem_wdata    = rf_read_data;
      end
      FILL_RD: begin
        mem_req  = 1'b1;
        mem_addr = memIdxAddr;
      end
      FILL_WR: begin
        rf_write      = 1'b1;
        rf_write_addr = regIdx;
        rf_write_data = holdReg;
      end
`ifdef SCHWAP_AUTOSWAP_EN
      SWAP: begin
        schwap_clk = 1'b1;
        schwap_reg = bankLatched;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_schwap_spill_fill.sv
// Directed bench for schwap_spill_fill: memory/register-file models with programmable ack delay.
// Also covers the SCHWAP_AUTOSWAP_EN build when that macro is defined.
module tb_schwap_spill_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [15:0] cmd_base;
`ifdef SCHWAP_AUTOSWAP_EN
  logic [3:0]  cmd_bank;
  logic [3:0]  schwap_reg;
  logic        schwap_clk;
`endif
  logic        busy, done;
  logic [3:0]  rf_read_addr;
  logic [15:0] rf_read_data;
  logic        rf_write;
  logic [3:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

`ifdef SCHWAP_AUTOSWAP_EN
  localparam int SpillLat = 6;
`else
  localparam int SpillLat = 5;
`endif

  logic [15:0] rfInit  [0:15];
  logic [15:0] memInit [0:65535];
  int ackDelay = 0;
  int waitCnt = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int acceptCyc = 0;
  int doneCyc = 0;

  logic [15:0] wrAddrQ[$];
  logic [15:0] wrDataQ[$];
  int          wrCycQ[$];
  logic [3:0]  rfAddrQ[$];
  logic [15:0] rfDataQ[$];
  int doneCnt = 0;
  int rfBack2Back = 0;
  int stableErr = 0;
  logic prevRfWrite = 1'b0;
  logic prevReqWait = 1'b0;
  logic [15:0] prevAddr = '0;
  logic prevWe = 1'b0;
`ifdef SCHWAP_AUTOSWAP_EN
  int swapCnt = 0;
  int swapCyc = 0;
  logic [3:0] swapReg = '0;
`endif

  schwap_spill_fill dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_base(cmd_base),
`ifdef SCHWAP_AUTOSWAP_EN
    .cmd_bank(cmd_bank), .schwap_reg(schwap_reg), .schwap_clk(schwap_clk),
`endif
    .busy(busy), .done(done), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write(rf_write), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  assign rf_read_data = rfInit[rf_read_addr];
  assign mem_rdata    = memInit[mem_addr];
  assign mem_ack      = mem_req && (waitCnt >= ackDelay);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    waitCnt <= (mem_req && !mem_ack) ? waitCnt + 1 : 0;
    if (mem_req && mem_ack && mem_we) begin
      wrAddrQ.push_back(mem_addr);
      wrDataQ.push_back(mem_wdata);
      wrCycQ.push_back(cyc);
    end
    if (rf_write) begin
      rfAddrQ.push_back(rf_write_addr);
      rfDataQ.push_back(rf_write_data);
      if (prevRfWrite) rfBack2Back <= rfBack2Back + 1;
    end
    prevRfWrite <= rf_write;
    if (done) doneCnt <= doneCnt + 1;
    if (prevReqWait && mem_req && (mem_addr !== prevAddr || mem_we !== prevWe))
      stableErr <= stableErr + 1;
    prevReqWait <= mem_req && !mem_ack;
    prevAddr <= mem_addr;
    prevWe <= mem_we;
`ifdef SCHWAP_AUTOSWAP_EN
    if (schwap_clk) begin
      swapCnt <= swapCnt + 1;
      swapCyc <= cyc;
      swapReg <= schwap_reg;
    end
`endif
  end

  task automatic issue(input logic op, input logic [15:0] base, input logic [3:0] bank);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
`ifdef SCHWAP_AUTOSWAP_EN
    cmd_bank  = bank;
`else
    if (bank != 4'd0) cmd_op = op;
`endif
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, output int lat);
    bit seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        doneCyc = cyc;
        lat = doneCyc - acceptCyc + 1;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: done not seen within 200 cycles, required a done pulse", name);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({cmd_ready, busy, done, rf_write, mem_req, mem_we} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 100000", {cmd_ready, busy, done, rf_write, mem_req, mem_we});
    end
    checks++;
    if ((rf_read_addr | rf_write_addr) !== 4'd0 || (mem_addr | mem_wdata | rf_write_data) !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: rd=%h wa=%h ma=%h wd=%h rwd=%h required all 0",
               rf_read_addr, rf_write_addr, mem_addr, mem_wdata, rf_write_data);
    end
  endtask

  task automatic test_reset_mid_fill;
    int rfCount;
    ackDelay = 1;
    for (int i = 0; i < 4; i++) memInit[16'h0500 + i] = 16'h5000 + 16'(i);
    issue(1'b1, 16'h0500, 4'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    rfCount = rfAddrQ.size();
    @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, rf_write, mem_req, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_fill: ready/rfw/req/busy=%b required 1000", {cmd_ready, rf_write, mem_req, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rfAddrQ.size() !== rfCount || {rf_write, mem_req, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_activity: rf writes %0d->%0d, rfw/req/busy=%b required none, 000",
               rfCount, rfAddrQ.size(), {rf_write, mem_req, busy});
    end
  endtask

  task automatic test_spill;
    int s, lat;
    logic [15:0] exp;
    rfInit[12] = 16'hAAAA; rfInit[13] = 16'hBBBB; rfInit[14] = 16'hCCCC; rfInit[15] = 16'hDDDD;
    ackDelay = 0;
    s = wrAddrQ.size();
    issue(1'b0, 16'h0100, 4'd0);
    waitDone("spill", lat);
    checks++;
    if (lat !== SpillLat) begin
      errors++;
      $display("FAIL spill_latency: got %0d required %0d", lat, SpillLat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL spill_done_pulse: done=%b ready=%b required 0 1", done, cmd_ready);
    end
    checks++;
    if (wrAddrQ.size() - s !== 4) begin
      errors++;
      $display("FAIL spill_count: got %0d writes required 4", wrAddrQ.size() - s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = 16'hAAAA + 16'(i) * 16'h1111;
        checks++;
        if (wrAddrQ[s+i] !== 16'h0100 + 16'(i) || wrDataQ[s+i] !== exp) begin
          errors++;
          $display("FAIL spill_word%0d: got %h:%h required %h:%h", i, wrAddrQ[s+i], wrDataQ[s+i],
                   16'h0100 + 16'(i), exp);
        end
        if (i > 0) begin
          checks++;
          if (wrCycQ[s+i] !== wrCycQ[s+i-1] + 1) begin
            errors++;
            $display("FAIL spill_consecutive%0d: cycle %0d after %0d", i, wrCycQ[s+i], wrCycQ[s+i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_fill(input int delay, input logic [15:0] base, input logic [15:0] first,
                           input int expLat);
    int s, b2b, st, lat;
    ackDelay = delay;
    for (int i = 0; i < 4; i++) memInit[base + 16'(i)] = first + 16'(i);
    s = rfAddrQ.size();
    b2b = rfBack2Back;
    st = stableErr;
    issue(1'b1, base, 4'd0);
    waitDone("fill", lat);
    @(posedge clk);
    #1;
    checks++;
    if (lat !== expLat) begin
      errors++;
      $display("FAIL fill_latency: got %0d required %0d", lat, expLat);
    end
    checks++;
    if (rfAddrQ.size() - s !== 4 || rfBack2Back !== b2b) begin
      errors++;
      $display("FAIL fill_pulses: got %0d writes (%0d adjacent) required 4 single-cycle",
               rfAddrQ.size() - s, rfBack2Back - b2b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rfAddrQ[s+i] !== 4'd12 + 4'(i) || rfDataQ[s+i] !== first + 16'(i)) begin
          errors++;
          $display("FAIL fill_reg%0d: got r%0d=%h required r%0d=%h", i, rfAddrQ[s+i], rfDataQ[s+i],
                   12 + i, first + 16'(i));
        end
      end
    end
    checks++;
    if (stableErr !== st) begin
      errors++;
      $display("FAIL fill_addr_stable: %0d changes while waiting for ack, required 0", stableErr - st);
    end
  endtask

  task automatic test_wrap;
    int s, lat;
    ackDelay = 0;
    s = wrAddrQ.size();
    issue(1'b0, 16'hFFFE, 4'd0);
    waitDone("wrap", lat);
    checks++;
    if (wrAddrQ.size() - s !== 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d writes required 4", wrAddrQ.size() - s);
    end else begin
      checks++;
      if ({wrAddrQ[s], wrAddrQ[s+1], wrAddrQ[s+2], wrAddrQ[s+3]} !== 64'hFFFE_FFFF_0000_0001) begin
        errors++;
        $display("FAIL wrap_addrs: got %h %h %h %h required FFFE FFFF 0000 0001",
                 wrAddrQ[s], wrAddrQ[s+1], wrAddrQ[s+2], wrAddrQ[s+3]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int d0, s, lat;
    ackDelay = 0;
    @(posedge clk);
    #1;
    d0 = doneCnt;
    s = wrAddrQ.size();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 16'h0400;
`ifdef SCHWAP_AUTOSWAP_EN
    cmd_bank = 4'd1;
`endif
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: ready=%b busy=%b required 0 1", cmd_ready, busy);
    end
    waitDone("b2b_first", lat);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_after_done: ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b required 1", busy);
    end
    waitDone("b2b_second", lat);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (doneCnt - d0 !== 2 || wrAddrQ.size() - s !== 8) begin
      errors++;
      $display("FAIL b2b_counts: done=%0d writes=%0d required 2 and 8", doneCnt - d0, wrAddrQ.size() - s);
    end
  endtask

`ifdef SCHWAP_AUTOSWAP_EN
  task automatic test_autoswap;
    int c0, s, lat;
    ackDelay = 0;
    c0 = swapCnt;
    s = wrAddrQ.size();
    issue(1'b0, 16'h0600, 4'd5);
    waitDone("autoswap", lat);
    @(posedge clk);
    #1;
    checks++;
    if (swapCnt - c0 !== 1 || swapReg !== 4'd5) begin
      errors++;
      $display("FAIL autoswap_pulse: pulses=%0d reg=%0d required 1 and 5", swapCnt - c0, swapReg);
    end
    checks++;
    if (wrAddrQ.size() - s !== 4 || swapCyc !== wrCycQ[s+3] + 1 || doneCyc !== swapCyc + 1) begin
      errors++;
      $display("FAIL autoswap_timing: swap cycle %0d done cycle %0d required %0d and %0d",
               swapCyc, doneCyc, wrCycQ[wrCycQ.size()-1] + 1, wrCycQ[wrCycQ.size()-1] + 2);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_base = '0;
`ifdef SCHWAP_AUTOSWAP_EN
    cmd_bank = '0;
`endif
    for (int i = 0; i < 16; i++) rfInit[i] = 16'(i) * 16'h0101;
    for (int i = 0; i < 65536; i++) memInit[i] = 16'hDEAD;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_reset_mid_fill;
    test_spill;
    test_fill(1, 16'h0200, 16'h0001, 13);
    test_fill(0, 16'h0300, 16'h7FF0, 9);
    test_wrap;
    test_back_to_back;
`ifdef SCHWAP_AUTOSWAP_EN
    test_autoswap;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
